// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - domain-side signal bundle of the reset sequencer
interface reset_sequencer_if #(
  parameter int N_DOMAINS = 4,
  parameter int DW        = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1
);
  logic                 i_soft_rst;
  logic [N_DOMAINS-1:0] i_ready;
  logic [N_DOMAINS-1:0] o_rst_domain;
  logic                 o_done;
  logic                 o_error;
  logic [DW-1:0]        o_error_domain;

  modport slave (
    input  i_soft_rst, i_ready,
    output o_rst_domain, o_done, o_error, o_error_domain
  );

  modport master (
    output i_soft_rst, i_ready,
    input  o_rst_domain, o_done, o_error, o_error_domain
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases N reset domains in index order, gated by per-domain ready with timeout
module reset_sequencer #(
  parameter int N_DOMAINS      = 4,
  parameter int HOLD_CLOCKS    = 4,
  parameter int TIMEOUT_CLOCKS = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  reset_sequencer_if.slave bus
);

  localparam int HW = $clog2(HOLD_CLOCKS + 1);
  localparam int TW = $clog2(TIMEOUT_CLOCKS + 1);
  localparam int KW = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CLOCKS - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLOCKS - 1);
  localparam logic [KW-1:0] K_LAST    = KW'(N_DOMAINS - 1);

  typedef enum logic [2:0] {
    S_RESET,
    S_HOLD,
    S_RELEASE,
    S_DONE,
    S_ERROR
  } state_t;

  logic [1:0]           r_sync;
  state_t               r_state;
  logic [HW-1:0]        r_hold_cnt;
  logic [TW-1:0]        r_timer;
  logic [KW-1:0]        r_k;
  logic [N_DOMAINS-1:0] r_rst_domain;
  logic                 r_done;
  logic                 r_error;
  logic [KW-1:0]        r_error_domain;

  state_t               w_state_nxt;
  logic [HW-1:0]        w_hold_nxt;
  logic [TW-1:0]        w_timer_nxt;
  logic [KW-1:0]        w_k_nxt;
  logic [KW-1:0]        w_k_inc;
  logic [N_DOMAINS-1:0] w_rst_nxt;
  logic                 w_done_nxt;
  logic                 w_error_nxt;
  logic [KW-1:0]        w_error_domain_nxt;

  // Assertion is asynchronous through the preset; release ripples through two flops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], 1'b0};
    end
  end

  assign w_k_inc = r_k + KW'(1);

  always_comb begin
    w_state_nxt        = r_state;
    w_hold_nxt         = r_hold_cnt;
    w_timer_nxt        = r_timer;
    w_k_nxt            = r_k;
    w_rst_nxt          = r_rst_domain;
    w_done_nxt         = r_done;
    w_error_nxt        = r_error;
    w_error_domain_nxt = r_error_domain;

    if (r_state != S_RESET && bus.i_soft_rst) begin
      w_state_nxt        = S_HOLD;
      w_hold_nxt         = '0;
      w_timer_nxt        = '0;
      w_k_nxt            = '0;
      w_rst_nxt          = '1;
      w_done_nxt         = 1'b0;
      w_error_nxt        = 1'b0;
      w_error_domain_nxt = '0;
    end else begin
      case (r_state)
        S_RESET: begin
          if (!r_sync[1]) begin
            w_state_nxt = S_HOLD;
            w_hold_nxt  = '0;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            w_state_nxt  = S_RELEASE;
            w_k_nxt      = '0;
            w_rst_nxt[0] = 1'b0;
            w_timer_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + HW'(1);
          end
        end
        S_RELEASE: begin
          // Ready takes priority over an expiring timer in the same cycle.
          if (bus.i_ready[r_k]) begin
            if (r_k == K_LAST) begin
              w_state_nxt = S_DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_k_nxt            = w_k_inc;
              w_rst_nxt[w_k_inc] = 1'b0;
              w_timer_nxt        = '0;
            end
          end else if (r_timer == TMO_LAST) begin
            w_state_nxt        = S_ERROR;
            w_error_nxt        = 1'b1;
            w_error_domain_nxt = r_k;
          end else begin
            w_timer_nxt = r_timer + TW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_RESET;
      r_hold_cnt     <= '0;
      r_timer        <= '0;
      r_k            <= '0;
      r_rst_domain   <= '1;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_error_domain <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_hold_cnt     <= w_hold_nxt;
      r_timer        <= w_timer_nxt;
      r_k            <= w_k_nxt;
      r_rst_domain   <= w_rst_nxt;
      r_done         <= w_done_nxt;
      r_error        <= w_error_nxt;
      r_error_domain <= w_error_domain_nxt;
    end
  end

  assign bus.o_rst_domain   = r_rst_domain;
  assign bus.o_done         = r_done;
  assign bus.o_error        = r_error;
  assign bus.o_error_domain = r_error_domain;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - scoreboard bench for reset_sequencer (N=4, HOLD=4, TIMEOUT=16)
module tb_reset_sequencer;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    int         at;
    logic [3:0] rst_dom;
    logic       done;
    logic       err;
    logic [1:0] dom;
    string      name;
  } exp_t;

  exp_t sb[$];

  reset_sequencer_if #(.N_DOMAINS(4)) bus ();

  reset_sequencer #(
    .N_DOMAINS     (4),
    .HOLD_CLOCKS   (4),
    .TIMEOUT_CLOCKS(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic push(input int at, input logic [3:0] r, input logic d, input logic e,
                      input logic [1:0] dm, input string nm);
    exp_t x;
    x.at = at; x.rst_dom = r; x.done = d; x.err = e; x.dom = dm; x.name = nm;
    sb.push_back(x);
  endtask

  // Asserts i_rst for two cycles and releases it mid-cycle; edge 0 is the next rising edge.
  task automatic reset_release(output int base);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = cyc + 1;
  endtask

  task automatic push_nominal(input int base);
    for (int e = 0; e <= 5; e++) push(base + e, 4'b1111, 1'b0, 1'b0, 2'd0, "nom_hold");
    push(base + 6,  4'b1110, 1'b0, 1'b0, 2'd0, "nom_rel0");
    push(base + 7,  4'b1100, 1'b0, 1'b0, 2'd0, "nom_rel1");
    push(base + 8,  4'b1000, 1'b0, 1'b0, 2'd0, "nom_rel2");
    push(base + 9,  4'b0000, 1'b0, 1'b0, 2'd0, "nom_rel3");
    push(base + 10, 4'b0000, 1'b1, 1'b0, 2'd0, "nom_done");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_soft_rst = 1'b0;
    bus.i_ready = 4'b1111;
    #1;
    checks++;
    if (bus.o_rst_domain !== 4'b1111 || bus.o_done !== 1'b0 || bus.o_error !== 1'b0 || bus.o_error_domain !== 2'd0) begin
      failures++;
      $display("FAIL reset_initial: rst=%b done=%b err=%b dom=%0d, expected 1111/0/0/0",
               bus.o_rst_domain, bus.o_done, bus.o_error, bus.o_error_domain);
    end
    bus.i_soft_rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.o_rst_domain !== 4'b1111 || bus.o_done !== 1'b0 || bus.o_error !== 1'b0) begin
      failures++;
      $display("FAIL reset_held: rst=%b done=%b err=%b, expected 1111/0/0",
               bus.o_rst_domain, bus.o_done, bus.o_error);
    end
    bus.i_soft_rst = 1'b0;
  endtask

  task automatic test_nominal();
    int   base;
    exp_t x;
    bus.i_ready = 4'b1111;
    reset_release(base);
    push_nominal(base);
    push(base + 11, 4'b0000, 1'b1, 1'b0, 2'd0, "nom_done_sticky");
    push(base + 12, 4'b0000, 1'b1, 1'b0, 2'd0, "nom_done_sticky");
    while (sb.size() > 0) begin
      @(negedge clk);
      if (cyc == base + 10) bus.i_ready = 4'b0000;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        x = sb.pop_front();
        checks++;
        if (x.at != cyc || bus.o_rst_domain !== x.rst_dom || bus.o_done !== x.done ||
            bus.o_error !== x.err || bus.o_error_domain !== x.dom) begin
          failures++;
          $display("FAIL %s @%0d: rst=%b done=%b err=%b dom=%0d, expected @%0d rst=%b done=%b err=%b dom=%0d",
                   x.name, cyc - base, bus.o_rst_domain, bus.o_done, bus.o_error, bus.o_error_domain,
                   x.at - base, x.rst_dom, x.done, x.err, x.dom);
        end
      end
    end
  endtask

  task automatic test_soft_reset(input string tag);
    int   c;
    exp_t x;
    @(negedge clk);
    c = cyc;
    bus.i_soft_rst = 1'b1;
    bus.i_ready = 4'b1111;
    for (int e = 1; e <= 6; e++) push(c + e, 4'b1111, 1'b0, 1'b0, 2'd0, {tag, "_hold"});
    push(c + 7,  4'b1110, 1'b0, 1'b0, 2'd0, {tag, "_rel0"});
    push(c + 8,  4'b1100, 1'b0, 1'b0, 2'd0, {tag, "_rel1"});
    push(c + 9,  4'b1000, 1'b0, 1'b0, 2'd0, {tag, "_rel2"});
    push(c + 10, 4'b0000, 1'b0, 1'b0, 2'd0, {tag, "_rel3"});
    push(c + 11, 4'b0000, 1'b1, 1'b0, 2'd0, {tag, "_done"});
    while (sb.size() > 0) begin
      @(negedge clk);
      if (cyc == c + 3) bus.i_soft_rst = 1'b0;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        x = sb.pop_front();
        checks++;
        if (x.at != cyc || bus.o_rst_domain !== x.rst_dom || bus.o_done !== x.done ||
            bus.o_error !== x.err || bus.o_error_domain !== x.dom) begin
          failures++;
          $display("FAIL %s @%0d: rst=%b done=%b err=%b dom=%0d, expected @%0d rst=%b done=%b err=%b dom=%0d",
                   x.name, cyc - c, bus.o_rst_domain, bus.o_done, bus.o_error, bus.o_error_domain,
                   x.at - c, x.rst_dom, x.done, x.err, x.dom);
        end
      end
    end
  endtask

  task automatic test_staggered();
    int   base;
    exp_t x;
    bus.i_ready = 4'b1101;
    reset_release(base);
    push(base + 6, 4'b1110, 1'b0, 1'b0, 2'd0, "stag_rel0");
    for (int e = 7; e <= 11; e++) push(base + e, 4'b1100, 1'b0, 1'b0, 2'd0, "stag_wait1");
    push(base + 12, 4'b1000, 1'b0, 1'b0, 2'd0, "stag_rel2");
    push(base + 13, 4'b0000, 1'b0, 1'b0, 2'd0, "stag_rel3");
    push(base + 14, 4'b0000, 1'b1, 1'b0, 2'd0, "stag_done");
    while (sb.size() > 0) begin
      @(negedge clk);
      if (cyc == base + 11) bus.i_ready[1] = 1'b1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        x = sb.pop_front();
        checks++;
        if (x.at != cyc || bus.o_rst_domain !== x.rst_dom || bus.o_done !== x.done ||
            bus.o_error !== x.err || bus.o_error_domain !== x.dom) begin
          failures++;
          $display("FAIL %s @%0d: rst=%b done=%b err=%b dom=%0d, expected @%0d rst=%b done=%b err=%b dom=%0d",
                   x.name, cyc - base, bus.o_rst_domain, bus.o_done, bus.o_error, bus.o_error_domain,
                   x.at - base, x.rst_dom, x.done, x.err, x.dom);
        end
      end
    end
  endtask

  task automatic test_collision();
    int   base;
    exp_t x;
    bus.i_ready = 4'b1011;
    reset_release(base);
    for (int e = 8; e <= 23; e++) push(base + e, 4'b1000, 1'b0, 1'b0, 2'd0, "coll_wait2");
    push(base + 24, 4'b0000, 1'b0, 1'b0, 2'd0, "coll_rel3");
    push(base + 25, 4'b0000, 1'b1, 1'b0, 2'd0, "coll_done");
    while (sb.size() > 0) begin
      @(negedge clk);
      if (cyc == base + 23) bus.i_ready[2] = 1'b1;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        x = sb.pop_front();
        checks++;
        if (x.at != cyc || bus.o_rst_domain !== x.rst_dom || bus.o_done !== x.done ||
            bus.o_error !== x.err || bus.o_error_domain !== x.dom) begin
          failures++;
          $display("FAIL %s @%0d: rst=%b done=%b err=%b dom=%0d, expected @%0d rst=%b done=%b err=%b dom=%0d",
                   x.name, cyc - base, bus.o_rst_domain, bus.o_done, bus.o_error, bus.o_error_domain,
                   x.at - base, x.rst_dom, x.done, x.err, x.dom);
        end
      end
    end
  endtask

  task automatic test_timeout();
    int   base;
    exp_t x;
    bus.i_ready = 4'b1011;
    reset_release(base);
    for (int e = 8; e <= 23; e++) push(base + e, 4'b1000, 1'b0, 1'b0, 2'd0, "tmo_wait2");
    for (int e = 24; e <= 28; e++) push(base + e, 4'b1000, 1'b0, 1'b1, 2'd2, "tmo_error");
    while (sb.size() > 0) begin
      @(negedge clk);
      if (cyc == base + 25) bus.i_ready = 4'b1111;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        x = sb.pop_front();
        checks++;
        if (x.at != cyc || bus.o_rst_domain !== x.rst_dom || bus.o_done !== x.done ||
            bus.o_error !== x.err || bus.o_error_domain !== x.dom) begin
          failures++;
          $display("FAIL %s @%0d: rst=%b done=%b err=%b dom=%0d, expected @%0d rst=%b done=%b err=%b dom=%0d",
                   x.name, cyc - base, bus.o_rst_domain, bus.o_done, bus.o_error, bus.o_error_domain,
                   x.at - base, x.rst_dom, x.done, x.err, x.dom);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int   base;
    exp_t x;
    bus.i_ready = 4'b1101;
    reset_release(base);
    for (int e = 7; e <= 9; e++) push(base + e, 4'b1100, 1'b0, 1'b0, 2'd0, "async_rel1");
    while (sb.size() > 0) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        x = sb.pop_front();
        checks++;
        if (x.at != cyc || bus.o_rst_domain !== x.rst_dom || bus.o_done !== x.done ||
            bus.o_error !== x.err || bus.o_error_domain !== x.dom) begin
          failures++;
          $display("FAIL %s @%0d: rst=%b done=%b err=%b dom=%0d, expected @%0d rst=%b done=%b err=%b dom=%0d",
                   x.name, cyc - base, bus.o_rst_domain, bus.o_done, bus.o_error, bus.o_error_domain,
                   x.at - base, x.rst_dom, x.done, x.err, x.dom);
        end
      end
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.o_rst_domain !== 4'b1111 || bus.o_done !== 1'b0 || bus.o_error !== 1'b0) begin
      failures++;
      $display("FAIL async_immediate: rst=%b done=%b err=%b, expected 1111/0/0",
               bus.o_rst_domain, bus.o_done, bus.o_error);
    end
    bus.i_ready = 4'b1111;
    reset_release(base);
    push_nominal(base);
    while (sb.size() > 0) begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        x = sb.pop_front();
        checks++;
        if (x.at != cyc || bus.o_rst_domain !== x.rst_dom || bus.o_done !== x.done ||
            bus.o_error !== x.err || bus.o_error_domain !== x.dom) begin
          failures++;
          $display("FAIL async_%s @%0d: rst=%b done=%b err=%b dom=%0d, expected @%0d rst=%b done=%b err=%b dom=%0d",
                   x.name, cyc - base, bus.o_rst_domain, bus.o_done, bus.o_error, bus.o_error_domain,
                   x.at - base, x.rst_dom, x.done, x.err, x.dom);
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_nominal();
    test_soft_reset("soft_from_done");
    test_staggered();
    test_collision();
    test_timeout();
    test_soft_reset("soft_from_error");
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Consumes the system reset produced by the reset manager.
- Releases the reset of N downstream domains one at a time, in index order.
- Before releasing the next domain it waits for the current domain to report ready, with a timeout on each wait.
- Reports sequence completion or failure to the top level, and supports a software-requested re-sequence without a full system reset.

Parameters:
- N_DOMAINS, 4, number of sequenced reset domains (2..16).
- HOLD_CLOCKS, 4, cycles all domain resets stay asserted after the synchronized release of i_rst (>=1).
- TIMEOUT_CLOCKS, 256, maximum cycles to wait for i_ready[k] after domain k is released (>=2).

Ports:
- i_clk  input  1  system clock.
- i_rst  input  1  asynchronous active-high reset.
- i_soft_rst  input  1  synchronous request to restart the sequence; level-sampled.
- i_ready  input  N_DOMAINS  per-domain ready indication, synchronous to i_clk.
- o_rst_domain  output  N_DOMAINS  per-domain active-high reset; bit k drives domain k.
- o_done  output  1  high while all domains are released and ready.
- o_error  output  1  high after a ready timeout.
- o_error_domain  output  max(1,$clog2(N_DOMAINS))  index of the domain that timed out.

Behaviour:
- Reset (i_rst=1, asynchronous):
  - o_rst_domain = all ones; o_done=0; o_error=0; o_error_domain=0.
  - State RESET; 2-FF synchronizer chain preset to 1.
- Release of i_rst:
  - Passes through a 2-FF synchronizer; assertion is asynchronous, deassertion is synchronous.
  - The internal synchronized reset falls on the 2nd rising edge after i_rst falls.
- All outputs are registered; no combinational path from inputs to outputs.
- States: RESET, HOLD, RELEASE, DONE, ERROR.
- RESET -> HOLD on the first edge with the synchronized reset low; hold counter cleared.
- HOLD:
  - Counter increments each cycle.
  - On the edge where counter == HOLD_CLOCKS-1: enter RELEASE with k=0, clear o_rst_domain[0] on that same edge, clear the timeout timer.
- RELEASE(k):
  - Only i_ready[k] is examined; other i_ready bits are ignored.
  - If i_ready[k]=1 and k<N-1: k<=k+1, clear o_rst_domain[k+1], reset the timer.
  - If i_ready[k]=1 and k==N-1: go to DONE; o_done<=1.
  - Else, if timer == TIMEOUT_CLOCKS-1: go to ERROR; o_error<=1; o_error_domain<=k.
  - Else timer increments.
  - Ready and timeout in the same cycle: ready wins.
  - Each domain takes at least 1 cycle; a domain whose ready is already high is released and accepted in one cycle.
- ERROR:
  - o_rst_domain keeps its value; domains 0..k stay released, domains k+1..N-1 stay in reset.
  - Stays in ERROR until i_rst or i_soft_rst.
- DONE:
  - o_done=1.
  - Later drops of i_ready are ignored; no automatic re-sequence.
- i_soft_rst=1 sampled in any state except RESET:
  - On the next edge: o_rst_domain = all ones, o_done=0, o_error=0, o_error_domain=0, state HOLD, counters cleared.
  - While i_soft_rst stays high, the FSM stays in HOLD with the counter held at 0.
  - The sequence starts HOLD_CLOCKS cycles after i_soft_rst falls.
- i_rst mid-sequence: immediate asynchronous return to the reset values, whatever the current state.
- Width rules:
  - Hold counter is $clog2(HOLD_CLOCKS+1) bits; timer is $clog2(TIMEOUT_CLOCKS+1) bits; k is o_error_domain width.
  - No counter wraps, because every comparison terminates the count.

Test Plan:
- Nominal sequence (N=4, HOLD=4, TIMEOUT=16):
  - Stimulus: i_ready tied 4'b1111; release i_rst at edge 0.
  - Required: o_rst_domain=1111 through edge 5; o_rst_domain[0] falls at edge 6 and bits 1..3 fall on edges 7..9; o_done=1 at edge 10.
- Staggered ready:
  - Stimulus: i_ready[1] rises 5 cycles after o_rst_domain[1] falls.
  - Required: o_rst_domain[2] falls exactly on the edge that samples i_ready[1]=1; no early release.
- Timeout:
  - Stimulus: i_ready[2] held 0.
  - Required: o_error=1 and o_error_domain=2 exactly 16 cycles after o_rst_domain[2] falls; o_rst_domain=1000 held; o_done=0.
- Ready/timeout collision:
  - Stimulus: i_ready[2] rises in the timer==15 cycle.
  - Required: no error; sequence continues to domain 3.
- Soft reset:
  - Stimulus: i_soft_rst pulsed 3 cycles in DONE, and again from ERROR.
  - Required: o_rst_domain=1111 and o_done/o_error=0 on the next edge; o_rst_domain[0] falls 4 cycles after i_soft_rst falls.
- Async reset mid-sequence:
  - Stimulus: assert i_rst between clock edges while in RELEASE(1).
  - Required: o_rst_domain=1111 immediately, before the next edge; the full sequence repeats after release with the 2-cycle synchronizer delay.
